// File: rtl/syncfifo.sv
// ---------------------------------------------------------------------------
// syncfifo : single-clock first-word-fall-through FIFO
//
// Buffers entries between two blocks in the same clock domain. It uses a
// write/can_write and read/can_read handshake. It reports its occupancy and
// has programmable almost-full and almost-empty thresholds. Storage is a
// plain register array. Every one of its 2**ADDR_WIDTH entries is usable.
//
// Parameters
//   DATA_WIDTH          bits per entry
//   ADDR_WIDTH          log2 of depth (DEPTH = 2**ADDR_WIDTH)
//   ALMOST_FULL_MARGIN  almost_full  when level >= DEPTH - margin
//   ALMOST_EMPTY_MARGIN almost_empty when level <= margin
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-high; empties the FIFO at once
//   write         push request, accepted when can_write
//   write_data    entry to push
//   can_write     FIFO not full
//   read          pop request, accepted when can_read
//   read_data     head entry; 0 while empty
//   can_read      FIFO not empty
//   level         occupancy 0..DEPTH
//   almost_full   threshold flag from level
//   almost_empty  threshold flag from level
//
// Optional build macro SYNCFIFO_ERROR_FLAGS_EN adds these ports:
//   clear_errors  clears both sticky flags on a clock edge
//   overflow      sticky; set after a write attempted while full
//   underflow     sticky; set after a read attempted while empty
// ---------------------------------------------------------------------------
module syncfifo #(
    parameter int DATA_WIDTH          = 16,
    parameter int ADDR_WIDTH          = 2,
    parameter int ALMOST_FULL_MARGIN  = 1,
    parameter int ALMOST_EMPTY_MARGIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  can_write,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  can_read,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
`ifdef SYNCFIFO_ERROR_FLAGS_EN
    output logic                  almost_empty,
    input  logic                  clear_errors,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  almost_empty
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
    localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_MARGIN);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH:0]   w_level;

    // The pointers carry one extra wrap bit. When the indices are equal, that
    // bit tells a full FIFO apart from an empty one.
    assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                     (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_level = r_wptr - r_rptr;

    assign w_wr_en = write && !w_full;
    assign w_rd_en = read && !w_empty;

    assign can_write    = !w_full;
    assign can_read     = !w_empty;
    assign level        = w_level;
    assign almost_full  = (w_level >= AF_THRESH);
    assign almost_empty = (w_level <= AE_THRESH);

    // Gate the head to zero when empty, so stale array contents never
    // appear on the output.
    assign read_data = w_empty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    // The array contents are not reset. Only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= write_data;
    end

`ifdef SYNCFIFO_ERROR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // A set event takes priority over clear_errors in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (write && w_full)        r_overflow <= 1'b1;
            else if (clear_errors)      r_overflow <= 1'b0;
            if (read && w_empty)        r_underflow <= 1'b1;
            else if (clear_errors)      r_underflow <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_syncfifo.sv
// ---------------------------------------------------------------------------
// tb_syncfifo : self-checking bench for syncfifo (default parameters).
// A queue holds the expected FIFO contents. Occupancy, flags and head data
// are derived from that queue.
// ---------------------------------------------------------------------------
module tb_syncfifo;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFM   = 1;
    localparam int AEM   = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          write;
    logic [DW-1:0] write_data;
    logic          can_write;
    logic          read;
    logic [DW-1:0] read_data;
    logic          can_read;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;
`ifdef SYNCFIFO_ERROR_FLAGS_EN
    logic          clear_errors;
    logic          overflow;
    logic          underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    syncfifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_MARGIN(AFM), .ALMOST_EMPTY_MARGIN(AEM)
    ) dut (
        .clk(clk), .reset(reset),
        .write(write), .write_data(write_data), .can_write(can_write),
        .read(read), .read_data(read_data), .can_read(can_read),
        .level(level), .almost_full(almost_full),
`ifdef SYNCFIFO_ERROR_FLAGS_EN
        .almost_empty(almost_empty),
        .clear_errors(clear_errors), .overflow(overflow), .underflow(underflow)
`else
        .almost_empty(almost_empty)
`endif
    );

    // One clock: drive inputs, cross the rising edge, and update the model
    // from the pre-edge occupancy. Outputs are stable #1 after the edge.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
        bit wacc, racc;
        write = w; write_data = d; read = r;
        wacc = w && (q.size() < DEPTH);
        racc = r && (q.size() > 0);
        @(posedge clk);
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(d);
        #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'b0; read = 1'b0; write_data = '0;
`ifdef SYNCFIFO_ERROR_FLAGS_EN
        clear_errors = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (can_write !== 1'b1) begin n_err++; $display("FAIL rst_can_write got %b want 1", can_write); end
        n_cmp++; if (can_read !== 1'b0) begin n_err++; $display("FAIL rst_can_read got %b want 0", can_read); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
        n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_err++; $display("FAIL rst_flags got ae=%b af=%b want ae=1 af=0", almost_empty, almost_full); end
        n_cmp++; if (read_data !== 16'h0) begin n_err++; $display("FAIL rst_read_data got %h want 0000", read_data); end
        q.delete();
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals[5] = '{16'hdead, 16'hbeef, 16'hfeed, 16'hface, 16'hd00b};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vals[i], 1'b0);
            n_cmp++; if (level !== 3'(i < 4 ? i + 1 : 4)) begin n_err++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, (i < 4 ? i + 1 : 4)); end
            if (i == 2) begin
                n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL fill_af_at3 got %b want 1", almost_full); end
            end
        end
        n_cmp++; if (can_write !== 1'b0) begin n_err++; $display("FAIL fill_can_write got %b want 0", can_write); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (read_data !== vals[i]) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, read_data, vals[i]); end
            cycle(1'b0, '0, 1'b1);
        end
        n_cmp++; if (can_read !== 1'b0 || level !== 3'd0) begin n_err++; $display("FAIL drain_empty got cr=%b lvl=%0d want cr=0 lvl=0", can_read, level); end
    endtask

    task automatic test_refill();
        cycle(1'b1, 16'hf00f, 1'b0);
        n_cmp++; if (can_read !== 1'b1 || read_data !== 16'hf00f) begin n_err++; $display("FAIL refill_head got cr=%b %h want cr=1 f00f", can_read, read_data); end
        cycle(1'b0, '0, 1'b1);
        n_cmp++; if (level !== 3'd0 || read_data !== 16'h0) begin n_err++; $display("FAIL refill_pop got lvl=%0d %h want 0 0000", level, read_data); end
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] exp_head;
            exp_head = q[0];
            n_cmp++; if (read_data !== exp_head) begin n_err++; $display("FAIL b2b_head[%0d] got %h want %h", i, read_data, exp_head); end
            cycle(1'b1, 16'(16'h3000 + i), 1'b1);
            n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL b2b_level[%0d] got %0d want 2", i, level); end
        end
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0);
        cycle(1'b1, 16'hbad0, 1'b1);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL simul_full_level got %0d want 3", level); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (read_data !== 16'(16'h4000 + i)) begin n_err++; $display("FAIL simul_full_order[%0d] got %h want %h", i, read_data, 16'(16'h4000 + i)); end
            cycle(1'b0, '0, 1'b1);
        end
        cycle(1'b1, 16'h5a5a, 1'b1);
        n_cmp++; if (level !== 3'd1 || read_data !== 16'h5a5a) begin n_err++; $display("FAIL simul_empty got lvl=%0d %h want 1 5a5a", level, read_data); end
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic w, r;
            int exp_n;
            w = ($urandom_range(0, 99) < (i < 200 ? 65 : 35));
            r = ($urandom_range(0, 99) < (i < 200 ? 35 : 65));
            write = w; read = r;
            #1;
            exp_n = q.size();
            n_cmp++; if (level !== 3'(exp_n)) begin n_err++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, level, exp_n); end
            n_cmp++; if (can_write !== (exp_n < DEPTH) || can_read !== (exp_n > 0)) begin n_err++; $display("FAIL rnd_hs[%0d] got cw=%b cr=%b lvl_model=%0d", i, can_write, can_read, exp_n); end
            n_cmp++; if (almost_full !== (exp_n >= DEPTH - AFM) || almost_empty !== (exp_n <= AEM)) begin n_err++; $display("FAIL rnd_flags[%0d] got af=%b ae=%b lvl_model=%0d", i, almost_full, almost_empty, exp_n); end
            n_cmp++; if (read_data !== (exp_n > 0 ? q[0] : 16'h0)) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", i, read_data, (exp_n > 0 ? q[0] : 16'h0)); end
            cycle(w, 16'($urandom), r);
        end
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h7000 + i), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (level !== 3'd0 || can_read !== 1'b0 || can_write !== 1'b1) begin n_err++; $display("FAIL async_rst got lvl=%0d cr=%b cw=%b want 0 0 1", level, can_read, can_write); end
        n_cmp++; if (read_data !== 16'h0 || almost_empty !== 1'b1) begin n_err++; $display("FAIL async_rst_out got %h ae=%b want 0000 1", read_data, almost_empty); end
        q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b1, 16'h8888, 1'b0);
        n_cmp++; if (level !== 3'd1 || read_data !== 16'h8888) begin n_err++; $display("FAIL post_rst got lvl=%0d %h want 1 8888", level, read_data); end
        cycle(1'b0, '0, 1'b1);
    endtask

`ifdef SYNCFIFO_ERROR_FLAGS_EN
    task automatic test_error_flags();
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL err_init got ov=%b un=%b want 0 0", overflow, underflow); end
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i), 1'b0);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL err_no_ov got %b want 0", overflow); end
        cycle(1'b1, 16'hffff, 1'b0);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL err_ov got %b want 1", overflow); end
        while (q.size() > 0) cycle(1'b0, '0, 1'b1);
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL err_no_un got %b want 0", underflow); end
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b1) begin n_err++; $display("FAIL err_sticky got ov=%b un=%b want 1 1", overflow, underflow); end
        clear_errors = 1'b1;
        cycle(1'b0, '0, 1'b1);
        clear_errors = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b1) begin n_err++; $display("FAIL err_set_wins got ov=%b un=%b want 0 1", overflow, underflow); end
        clear_errors = 1'b1;
        cycle(1'b0, '0, 1'b0);
        clear_errors = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL err_clear got ov=%b un=%b want 0 0", overflow, underflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_refill();
        test_back_to_back();
        test_simultaneous();
        test_random();
        test_async_reset();
`ifdef SYNCFIFO_ERROR_FLAGS_EN
        test_error_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/syncfifo.md
Name: syncfifo

Overview:
Single-clock, parametrised FIFO for intra-domain buffering in the graphics pipeline, e.g. between the command decoder and pixel writer. It keeps the write/can_write and read/can_read handshake style of the cross-domain FIFO. It adds configurable width and depth, first-word-fall-through output, an occupancy count, and programmable almost-full/almost-empty flags. Storage is an internal register array, with no dual-port buffer instance.

Parameters:
DATA_WIDTH, 16, bits per entry
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH entries, all usable
ALMOST_FULL_MARGIN, 1, almost_full asserts when level >= DEPTH - ALMOST_FULL_MARGIN
ALMOST_EMPTY_MARGIN, 1, almost_empty asserts when level <= ALMOST_EMPTY_MARGIN

Ports:
clk  in  1  sole clock, all state on rising edge
reset  in  1  asynchronous, active-high
write  in  1  push request
write_data  in  DATA_WIDTH  entry to push
can_write  out  1  FIFO not full
read  in  1  pop request
read_data  out  DATA_WIDTH  head entry (first-word-fall-through)
can_read  out  1  FIFO not empty
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
almost_full  out  1  threshold flag
almost_empty  out  1  threshold flag

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset clears pointers and level. Outputs during and after reset: can_write=1, can_read=0, level=0, almost_full=0, almost_empty=1, read_data=0. Array contents are not reset.
- Pointers: wptr and rptr are each ADDR_WIDTH+1 bits. The index is the low ADDR_WIDTH bits and wraps naturally. Full when the MSBs differ and the indices are equal; empty when the pointers are equal.
- level = wptr - rptr, taken modulo 2**(ADDR_WIDTH+1).
- can_write = !full and can_read = !empty. Both are combinational from registered pointers only, with no dependency on write or read.
- Write accepted iff write && can_write: mem[widx] <= write_data and wptr increments. A write while full is silently dropped.
- Read accepted iff read && can_read: rptr increments. A read while empty is ignored.
- read_data = can_read ? mem[ridx] : 0, combinational. The head is visible the cycle after the write that filled an empty FIFO, so write-to-read latency is 1 clk.
- Simultaneous write and read:
  - Empty: only the write is accepted; level goes 0 to 1.
  - Full: only the read is accepted; the write is dropped and level goes DEPTH to DEPTH-1.
  - Otherwise both are accepted and level is unchanged.
- almost_full and almost_empty are combinational from level. Both may be true at once for small DEPTH.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.
- Parameters must satisfy ALMOST_FULL_MARGIN <= DEPTH and ALMOST_EMPTY_MARGIN < DEPTH. No checking is done in RTL.

Optional Feature:
Macro SYNCFIFO_ERROR_FLAGS_EN.
- Defined: adds the following ports.
  - Input clear_errors (1 bit).
  - Output overflow (1 bit): sticky; set the cycle after a write with can_write=0.
  - Output underflow (1 bit): sticky; set the cycle after a read with can_read=0.
  - Both flags are cleared by reset or by clear_errors on a clock edge. If a set event and clear_errors coincide, the set wins.
- Not defined: these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset, then check idle state (DATA_WIDTH=16, ADDR_WIDTH=2) -> can_write=1, can_read=0, level=0, almost_empty=1, read_data=0.
- Write dead, beef, feed, face, d00b on consecutive clks -> level=4 and can_write=0 after the 4th write; almost_full=1 at level 3; d00b never read; reads return dead, beef, feed, face in order.
- Drain to empty, then write f00f -> can_read=1 and read_data=f00f one clk later; one read returns level to 0 and read_data to 0.
- Hold write and read together at level 2 for 6 clks -> level stays 2 and output order is preserved across pointer wrap.
- Write and read in the same clk at level 4 and at level 0 -> full: level=3 with the new write dropped; empty: level=1 with the new data at the head.
- With SYNCFIFO_ERROR_FLAGS_EN defined, write while full and read while empty -> overflow=1 and underflow=1 and they remain set; pulse clear_errors -> both 0. Assert reset mid-burst at level 3 -> level=0 immediately, without a clk edge.
